// File: rtl/seg7_mux_pwm.sv
// seg7_mux_pwm: N-digit multiplexed 7-segment driver with per-slot PWM dimming and tear-free frame updates
module seg7_mux_pwm #(
    parameter int N_DIGITS    = 4,
    parameter int SLOT_CYCLES = 262144,
    parameter int DIM_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dim_up,
    input  logic                  dim_dwn,
    output logic [DIM_W-1:0]      dim_val,
    input  logic                  x_wr,
    input  logic [4*N_DIGITS-1:0] x,
    input  logic [N_DIGITS-1:0]   x_dp,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_pls
);
    localparam int SW = $clog2(SLOT_CYCLES);
    localparam int GW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int OW = SW + DIM_W + 1;
    localparam logic [15:0][6:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t                r_state;
    logic [SW-1:0]         r_slot;
    logic [GW-1:0]         r_dig;
    logic [DIM_W-1:0]      r_dim_val;
    logic [DIM_W-1:0]      r_dim_act;
    logic [4*N_DIGITS-1:0] r_stg_x;
    logic [4*N_DIGITS-1:0] r_disp_x;
    logic [N_DIGITS-1:0]   r_stg_dp;
    logic [N_DIGITS-1:0]   r_disp_dp;
    logic                  r_pend;
    logic [N_DIGITS-1:0]   r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame;

    logic [OW-1:0]         w_on;
    logic                  w_slot_end;
    logic                  w_last;
    logic                  w_fstart;
    logic                  w_cut;
    logic                  w_blank;
    logic [3:0]            w_nib;
    logic [GW-1:0]         w_dig_nx;

    assign w_on       = ((OW'(r_dim_act) + OW'(1)) * OW'(SLOT_CYCLES)) >> DIM_W;
    assign w_slot_end = r_slot == SW'(SLOT_CYCLES - 1);
    assign w_last     = r_dig == GW'(N_DIGITS - 1);
    assign w_fstart   = en && (r_state == IDLE || (w_slot_end && w_last));
    assign w_cut      = r_state == ON && OW'(r_slot) == w_on - OW'(1) && w_on < OW'(SLOT_CYCLES);
    assign w_nib      = r_disp_x[{r_dig, 2'b00} +: 4];
    assign w_blank    = lz_blank && r_dig != '0 && (r_disp_x >> {r_dig, 2'b00}) == '0;
    assign w_dig_nx   = w_last ? '0 : r_dig + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_dig     <= '0;
            r_dim_val <= '1;
            r_dim_act <= '1;
            r_stg_x   <= '0;
            r_stg_dp  <= '0;
            r_disp_x  <= '0;
            r_disp_dp <= '0;
            r_pend    <= 1'b0;
            r_an      <= '1;
            r_seg     <= 7'h7F;
            r_dp      <= 1'b1;
            r_frame   <= 1'b0;
        end else begin
            r_dim_val <= dim_up && !dim_dwn && r_dim_val != '1 ? r_dim_val + 1'b1 :
                         dim_dwn && !dim_up && r_dim_val != '0 ? r_dim_val - 1'b1 : r_dim_val;
            if (w_fstart)
                r_dim_act <= r_dim_val;
            if (w_fstart && x_wr) begin
                r_disp_x  <= x;
                r_disp_dp <= x_dp;
            end else if (w_fstart && r_pend) begin
                r_disp_x  <= r_stg_x;
                r_disp_dp <= r_stg_dp;
            end
            if (x_wr) begin
                r_stg_x  <= x;
                r_stg_dp <= x_dp;
            end
            r_pend  <= (x_wr || r_pend) && !w_fstart;
            r_frame <= w_fstart && r_state != IDLE;
            if (!en) begin
                r_state <= IDLE;
                r_slot  <= '0;
                r_dig   <= '0;
            end else if (r_state == IDLE) begin
                r_state <= ON;
                r_slot  <= '0;
                r_dig   <= '0;
            end else if (w_slot_end) begin
                r_state <= ON;
                r_slot  <= '0;
                r_dig   <= w_dig_nx;
            end else begin
                r_slot  <= r_slot + 1'b1;
                r_state <= w_cut ? OFF : r_state;
            end
            r_an  <= r_state == ON ? ~(N_DIGITS'(1) << r_dig) : '1;
            r_seg <= r_state != ON || w_blank ? 7'h7F : HEX[w_nib];
            r_dp  <= r_state == ON ? ~r_disp_dp[r_dig] : 1'b1;
        end
    end

    assign dim_val   = r_dim_val;
    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign frame_pls = r_frame;
endmodule

// File: tb/tb_seg7_mux_pwm.sv
// tb_seg7_mux_pwm: scoreboard bench; stimulus queues cycle-stamped expectations, a negedge monitor checks them
module tb_seg7_mux_pwm;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dim_up;
    logic        dim_dwn;
    logic [1:0]  dim_val;
    logic        x_wr;
    logic [15:0] x;
    logic [3:0]  x_dp;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_pls;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int         cyc;
        bit         kind;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fp;
        logic [1:0] dim;
    } exp_t;

    exp_t q[$];
    exp_t m;

    seg7_mux_pwm #(.N_DIGITS(4), .SLOT_CYCLES(16), .DIM_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .dim_up(dim_up), .dim_dwn(dim_dwn), .dim_val(dim_val),
        .x_wr(x_wr), .x(x), .x_dp(x_dp), .lz_blank(lz_blank),
        .seg(seg), .dp(dp), .an(an), .frame_pls(frame_pls)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic push(input exp_t e);
        int i = q.size();
        while (i > 0 && q[i-1].cyc > e.cyc) i--;
        q.insert(i, e);
    endtask

    task automatic exp_d(input int c, input logic [3:0] a, input logic [6:0] s, input logic p, input logic f);
        exp_t e;
        e.cyc = c; e.kind = 1'b0; e.an = a; e.seg = s; e.dp = p; e.fp = f; e.dim = '0;
        push(e);
    endtask

    task automatic exp_v(input int c, input logic [1:0] v);
        exp_t e;
        e.cyc = c; e.kind = 1'b1; e.an = '0; e.seg = '0; e.dp = 1'b0; e.fp = 1'b0; e.dim = v;
        push(e);
    endtask

    task automatic exp_slot(input int f, input int d, input logic [6:0] s, input logic p, input int on);
        logic [3:0] a = ~(4'b0001 << d);
        exp_d(f + 16*d + 1, a, s, p, 1'b0);
        exp_d(f + 16*d + on, a, s, p, d == 3 && on == 16);
        if (on < 16) exp_d(f + 16*d + on + 1, 4'hF, 7'h7F, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(input int c, input logic up, input logic dn);
        wait_until(c);
        dim_up = up;
        dim_dwn = dn;
        tick();
        dim_up = 1'b0;
        dim_dwn = 1'b0;
    endtask

    task automatic write(input int c, input logic [15:0] v, input logic [3:0] p);
        wait_until(c);
        x = v;
        x_dp = p;
        x_wr = 1'b1;
        tick();
        x_wr = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            n_chk++;
            if (m.cyc != cyc)
                $display("FAIL missed@%0d: expectation not reached (now cycle %0d)", m.cyc, cyc);
            else if (m.kind) begin
                if (dim_val === m.dim) n_pass++;
                else $display("FAIL dim@%0d: dim_val=%0d want %0d", cyc, dim_val, m.dim);
            end else begin
                if (an === m.an && seg === m.seg && dp === m.dp && frame_pls === m.fp) n_pass++;
                else $display("FAIL disp@%0d: an=%b seg=%h dp=%b fp=%b want an=%b seg=%h dp=%b fp=%b",
                              cyc, an, seg, dp, frame_pls, m.an, m.seg, m.dp, m.fp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [3:0]  vp;
        int b, f, b2;
        rst = 1'b1; en = 1'b0; dim_up = 1'b0; dim_dwn = 1'b0;
        x_wr = 1'b0; x = '0; x_dp = '0; lz_blank = 1'b0;
        exp_d(2, 4'hF, 7'h7F, 1'b1, 1'b0);
        exp_v(2, 2'd3);
        exp_d(3, 4'hF, 7'h7F, 1'b1, 1'b0);
        wait_until(3);
        v = 16'h1234; vp = 4'b0000;
        rst = 1'b0; en = 1'b1; x = v; x_dp = vp; x_wr = 1'b1;
        b = 4;
        exp_d(b, 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) exp_slot(b + 64*k, d, hex7(v[4*d +: 4]), ~vp[d], 16);
        tick();
        x_wr = 1'b0;
        exp_v(b + 70, 2'd3); exp_v(b + 71, 2'd2); exp_v(b + 73, 2'd1);
        exp_v(b + 75, 2'd0); exp_v(b + 77, 2'd0); exp_v(b + 81, 2'd0);
        pulse(b + 70, 1'b0, 1'b1); pulse(b + 72, 1'b0, 1'b1); pulse(b + 74, 1'b0, 1'b1);
        pulse(b + 76, 1'b0, 1'b1); pulse(b + 80, 1'b1, 1'b1);
        f = b + 128;
        for (int d = 0; d < 4; d++) exp_slot(f, d, hex7(v[4*d +: 4]), 1'b1, 4);
        exp_v(f + 3, 2'd1); exp_v(f + 5, 2'd2);
        pulse(f + 2, 1'b1, 1'b0); pulse(f + 4, 1'b1, 1'b0);
        f = b + 192;
        exp_d(f, 4'hF, 7'h7F, 1'b1, 1'b1);
        for (int d = 0; d < 4; d++) exp_slot(f, d, hex7(v[4*d +: 4]), 1'b1, 12);
        write(f + 20, 16'hABCD, 4'b0101);
        f = b + 256;
        v = 16'hABCD; vp = 4'b0101;
        exp_d(f, 4'hF, 7'h7F, 1'b1, 1'b1);
        for (int d = 0; d < 4; d++) exp_slot(f, d, hex7(v[4*d +: 4]), ~vp[d], 12);
        wait_until(f + 20);
        lz_blank = 1'b1;
        write(f + 20, 16'h0050, 4'b0000);
        f = b + 320;
        exp_d(f, 4'hF, 7'h7F, 1'b1, 1'b1);
        exp_slot(f, 0, 7'h40, 1'b1, 12);
        exp_slot(f, 1, 7'h12, 1'b1, 12);
        exp_slot(f, 2, 7'h7F, 1'b1, 12);
        exp_slot(f, 3, 7'h7F, 1'b1, 12);
        write(f + 20, 16'h0000, 4'b0000);
        f = b + 384;
        exp_d(f, 4'hF, 7'h7F, 1'b1, 1'b1);
        exp_slot(f, 0, 7'h40, 1'b1, 12);
        exp_d(f + 17, 4'hD, 7'h7F, 1'b1, 1'b0);
        exp_d(f + 25, 4'hD, 7'h7F, 1'b1, 1'b0);
        exp_d(f + 26, 4'hF, 7'h7F, 1'b1, 1'b0);
        exp_d(f + 64, 4'hF, 7'h7F, 1'b1, 1'b0);
        exp_d(f + 65, 4'hF, 7'h7F, 1'b1, 1'b0);
        wait_until(f + 24);
        en = 1'b0;
        wait_until(f + 40);
        lz_blank = 1'b0;
        write(f + 40, 16'h1234, 4'b0000);
        wait_until(f + 70);
        en = 1'b1;
        b2 = f + 71;
        exp_d(b2, 4'hF, 7'h7F, 1'b1, 1'b0);
        exp_slot(b2, 0, 7'h19, 1'b1, 12);
        exp_slot(b2, 1, 7'h30, 1'b1, 12);
        exp_v(b2 + 37, 2'd2);
        exp_d(b2 + 41, 4'hF, 7'h7F, 1'b1, 1'b0);
        exp_v(b2 + 41, 2'd3);
        exp_d(b2 + 42, 4'hF, 7'h7F, 1'b1, 1'b0);
        pulse(b2 + 36, 1'b1, 1'b1);
        wait_until(b2 + 40);
        rst = 1'b1;
        wait_until(b2 + 43);
        if (q.size() > 0) begin
            $display("FAIL pending: %0d expectations never checked", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
